spi_sram_master: RTL and testbench
==================================

Name: spi_sram_master

Overview:
- Serial initiator for the SPI SRAM responder.
- Accepts single-byte read/write requests from a host-side valid/ready port.
- Serializes each request on sdoM as a frame, MSB first: 1 command bit, address, then write data; for reads it shifts read data in from sdoS.
- Drives the frame select and per-field strobes so the responder and the bench can align to each field.

Parameters:
ADDR_W, 8, address field width in bits
DATA_W, 8, data field width in bits
TURN_CYC, 2, read turnaround cycles between the last address bit and the first sampled data bit (0 allowed)
GAP_CYC, 1, cycles ss_n is held high after each frame (minimum 1)

Ports:
clock  in  1  single system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  high only in IDLE; a request is accepted on a cycle with req_valid&&req_ready
req_write  in  1  1=write, 0=read; captured at accept
req_addr  in  ADDR_W  target address; captured at accept
req_wdata  in  DATA_W  write data; captured at accept
done  out  1  one-cycle pulse at the end of every completed frame
rsp_rdata  out  DATA_W  last read data; updated only by reads
busy  out  1  high in every state except IDLE
ss_n  out  1  frame select, active-low
sdoM  out  1  serial data to the responder
sdoS  in  1  serial data from the responder
comload  out  1  high while the command bit is on sdoM
addrload  out  1  high while address bits are on sdoM
dataload  out  1  high while write bits are driven or read bits are sampled

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE; ss_n=1; sdoM=0; comload/addrload/dataload/done=0; rsp_rdata=0; bit counter=0.
  - Reset mid-frame aborts the frame: ss_n=1 on the following cycle, no done pulse, rsp_rdata unchanged from its reset value.
- States: IDLE, CMD, ADDR, WDATA, TURN, RDATA, GAP. All serial outputs are registered.
- IDLE:
  - req_ready=1.
  - On accept: latch req_write/addr/wdata into shift registers; go to CMD. Host inputs are ignored after accept.
  - req_valid outside IDLE is not accepted; the host holds it until req_ready.
- CMD, 1 cycle: ss_n=0, sdoM=command bit (1 write, 0 read), comload=1. Next state ADDR.
- ADDR, ADDR_W cycles: sdoM=addr[ADDR_W-1] down to addr[0], addrload=1. Next state WDATA for a write; for a read, TURN (or RDATA if TURN_CYC=0).
- WDATA, DATA_W cycles: sdoM=wdata MSB first, dataload=1. Next state GAP.
- TURN, TURN_CYC cycles: ss_n=0, sdoM=0, all strobes 0. Next state RDATA.
- RDATA, DATA_W cycles:
  - ss_n=0, sdoM=0, dataload=1.
  - sdoS is sampled at the rising edge ending each cycle and shifted into an internal register, MSB first.
  - Next state GAP.
- GAP, GAP_CYC cycles: ss_n=1, sdoM=0, strobes 0.
  - done=1 in the first GAP cycle only.
  - For reads, rsp_rdata takes the assembled byte in that same cycle and holds it until the next read completes.
  - Next state IDLE.
- Cycle timing with defaults, accept at cycle T:
  - Write: CMD T+1, ADDR T+2..T+9, WDATA T+10..T+17, done T+18, req_ready again T+19.
  - Read: CMD T+1, ADDR T+2..T+9, TURN T+10..T+11, RDATA T+12..T+19, done/rsp_rdata T+20, req_ready T+21.
- Counter sizing: bit counter is wide enough for max(ADDR_W, DATA_W, TURN_CYC, GAP_CYC); it reloads on every state entry and never wraps mid-field.
- Strobes are mutually exclusive and are 0 whenever ss_n=1.

Test Plan:
- Write req addr=0x31 wdata=0xA5 at T -> sdoM T+1..T+17 = 1, 0,0,1,1,0,0,0,1, 1,0,1,0,0,1,0,1; comload at T+1, addrload T+2..T+9, dataload T+10..T+17; done at T+18; rsp_rdata stays 0.
- Read req addr=0x32 with responder model driving 0x50 on sdoS T+12..T+19 -> sdoM command bit 0 then 0x32; done and rsp_rdata=0x50 at T+20; ss_n=0 from T+1 to T+19 inclusive.
- req_valid held high with two queued requests (write then read) -> second accept exactly at T+19; ss_n high for exactly GAP_CYC cycles between frames; no request dropped.
- Reset asserted at T+5 during ADDR -> ss_n=1, sdoM=0, strobes 0 at T+6; no done; req_ready=1 from T+6; a new read afterwards completes with correct data.
- TURN_CYC=0, GAP_CYC=3 build; read 0xFF from addr 0x00 -> RDATA starts T+10; done and rsp_rdata=0xFF at T+18; req_ready at T+21.
- Write of 0x00 to 0xFF followed by a read returning 0x5A -> rsp_rdata unchanged by the write and 0x5A after the read; busy low only in IDLE throughout.

Source files
------------

// File: rtl/spi_sram_master_if.sv
// Host request/response port and serial frame pins of the SPI SRAM initiator.
// The master modport is the initiator's view; slave is the host/responder side.
interface spi_sram_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              ss_n;
    logic              sdoM;
    logic              sdoS;
    logic              comload;
    logic              addrload;
    logic              dataload;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, sdoS,
        output req_ready, done, rsp_rdata, busy, ss_n, sdoM,
               comload, addrload, dataload
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, sdoS,
        input  req_ready, done, rsp_rdata, busy, ss_n, sdoM,
               comload, addrload, dataload
    );
endinterface

// File: rtl/spi_sram_master.sv
// SPI SRAM initiator: takes one read/write request at a time from the host
// and shifts it out as a framed command/address/data sequence, MSB first.
// Every serial output and strobe is a flop loaded on entry to the state that
// owns it, so the pins change only on clock edges.
module spi_sram_master #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic              clock,
    input  logic              reset,
    spi_sram_master_if.master bus
);
    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_TG = (TURN_CYC > GAP_CYC) ? TURN_CYC : GAP_CYC;
    localparam int MAXV   = (MAX_AD > MAX_TG) ? MAX_AD : MAX_TG;
    // Counter holds "cycles left minus one" for the current field.
    localparam int CNT_W  = (MAXV > 1) ? $clog2(MAXV) : 1;

    localparam logic [CNT_W-1:0] ADDR_LD = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_GAP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ss_n;
    logic              r_sdo;
    logic              r_com;
    logic              r_addrld;
    logic              r_datald;
    logic              r_done;

    logic              w_last;
    logic              w_accept;

    assign w_last   = (r_cnt == '0);
    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.rsp_rdata = r_rdata;
    assign bus.ss_n      = r_ss_n;
    assign bus.sdoM      = r_sdo;
    assign bus.comload   = r_com;
    assign bus.addrload  = r_addrld;
    assign bus.dataload  = r_datald;

    // Frame sequencer: state, field counter, shift registers and pin flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rx     <= '0;
            r_rdata  <= '0;
            r_ss_n   <= 1'b1;
            r_sdo    <= 1'b0;
            r_com    <= 1'b0;
            r_addrld <= 1'b0;
            r_datald <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only GAP entry raises it
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_state <= S_CMD;
                        r_ss_n  <= 1'b0;
                        r_sdo   <= bus.req_write;
                        r_com   <= 1'b1;
                    end
                end
                S_CMD: begin
                    r_state  <= S_ADDR;
                    r_com    <= 1'b0;
                    r_addrld <= 1'b1;
                    r_sdo    <= r_addr[ADDR_W-1];
                    r_addr   <= {r_addr[ADDR_W-2:0], 1'b0};
                    r_cnt    <= ADDR_LD;
                end
                S_ADDR: begin
                    if (!w_last) begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_sdo  <= r_addr[ADDR_W-1];
                        r_addr <= {r_addr[ADDR_W-2:0], 1'b0};
                    end else begin
                        r_addrld <= 1'b0;
                        if (r_write) begin
                            r_state  <= S_WDATA;
                            r_sdo    <= r_wdata[DATA_W-1];
                            r_wdata  <= {r_wdata[DATA_W-2:0], 1'b0};
                            r_datald <= 1'b1;
                            r_cnt    <= DATA_LD;
                        end else if (TURN_CYC > 0) begin
                            r_state <= S_TURN;
                            r_sdo   <= 1'b0;
                            r_cnt   <= TURN_LD;
                        end else begin
                            r_state  <= S_RDATA;
                            r_sdo    <= 1'b0;
                            r_datald <= 1'b1;
                            r_cnt    <= DATA_LD;
                        end
                    end
                end
                S_WDATA: begin
                    if (!w_last) begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_sdo   <= r_wdata[DATA_W-1];
                        r_wdata <= {r_wdata[DATA_W-2:0], 1'b0};
                    end else begin
                        r_state  <= S_GAP;
                        r_ss_n   <= 1'b1;
                        r_sdo    <= 1'b0;
                        r_datald <= 1'b0;
                        r_done   <= 1'b1;
                        r_cnt    <= GAP_LD;
                    end
                end
                S_TURN: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state  <= S_RDATA;
                        r_datald <= 1'b1;
                        r_cnt    <= DATA_LD;
                    end
                end
                S_RDATA: begin
                    // sdoS is valid for the whole RDATA cycle; take it at the closing edge
                    r_rx <= {r_rx[DATA_W-2:0], bus.sdoS};
                    if (!w_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rdata  <= {r_rx[DATA_W-2:0], bus.sdoS};
                        r_state  <= S_GAP;
                        r_ss_n   <= 1'b1;
                        r_datald <= 1'b0;
                        r_done   <= 1'b1;
                        r_cnt    <= GAP_LD;
                    end
                end
                S_GAP: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ss_n  <= 1'b1;
                    r_sdo   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_master.sv
// Directed bench for spi_sram_master: a default build and a TURN_CYC=0 /
// GAP_CYC=3 build. Each frame is recorded cycle by cycle after accept and
// compared against hand-built per-pin bit patterns (first cycle = MSB).
module tb_spi_sram_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic       sel = 1'b0;
    logic       valid_v = 1'b0;
    logic       write_v = 1'b0;
    logic [7:0] addr_v = 8'h00;
    logic [7:0] wdata_v = 8'h00;
    logic       sdoS_v = 1'b0;

    spi_sram_master_if #(.ADDR_W(8), .DATA_W(8)) d_if ();
    spi_sram_master_if #(.ADDR_W(8), .DATA_W(8)) a_if ();

    assign d_if.req_valid = valid_v & ~sel;
    assign d_if.req_write = write_v;
    assign d_if.req_addr  = addr_v;
    assign d_if.req_wdata = wdata_v;
    assign d_if.sdoS      = sdoS_v & ~sel;
    assign a_if.req_valid = valid_v & sel;
    assign a_if.req_write = write_v;
    assign a_if.req_addr  = addr_v;
    assign a_if.req_wdata = wdata_v;
    assign a_if.sdoS      = sdoS_v & sel;

    spi_sram_master #(.ADDR_W(8), .DATA_W(8), .TURN_CYC(2), .GAP_CYC(1)) u_dut (
        .clock(clk), .reset(rst), .bus(d_if.master));
    spi_sram_master #(.ADDR_W(8), .DATA_W(8), .TURN_CYC(0), .GAP_CYC(3)) u_alt (
        .clock(clk), .reset(rst), .bus(a_if.master));

    logic       m_ss, m_sdo, m_com, m_al, m_dl, m_done, m_rdy, m_busy;
    logic [7:0] m_rd;
    assign m_ss   = sel ? a_if.ss_n      : d_if.ss_n;
    assign m_sdo  = sel ? a_if.sdoM      : d_if.sdoM;
    assign m_com  = sel ? a_if.comload   : d_if.comload;
    assign m_al   = sel ? a_if.addrload  : d_if.addrload;
    assign m_dl   = sel ? a_if.dataload  : d_if.dataload;
    assign m_done = sel ? a_if.done      : d_if.done;
    assign m_rdy  = sel ? a_if.req_ready : d_if.req_ready;
    assign m_busy = sel ? a_if.busy      : d_if.busy;
    assign m_rd   = sel ? a_if.rsp_rdata : d_if.rsp_rdata;

    // Per-cycle recordings; after n samples, cycle k sits at bit n-k.
    logic [63:0] c_ss, c_sdo, c_com, c_al, c_dl, c_done, c_rdy, c_busy;
    logic [7:0]  c_rd [1:63];

    task automatic start(input logic s, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        sel = s; write_v = w; addr_v = a; wdata_v = d; valid_v = 1'b1;
        @(posedge clk);
    endtask

    // Records cycles T+1..T+n. At k==1 the host fields are replaced (they must
    // be ignored by the in-flight frame); valid drops at k==drop_k; the
    // responder drives rbyte MSB first during cycles rd_start..rd_start+7.
    task automatic capture(input int n, input logic [7:0] rbyte, input int rd_start,
                           input int drop_k, input logic nw, input logic [7:0] na,
                           input logic [7:0] nd);
        c_ss = '0; c_sdo = '0; c_com = '0; c_al = '0;
        c_dl = '0; c_done = '0; c_rdy = '0; c_busy = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            c_ss   = {c_ss[62:0], m_ss};
            c_sdo  = {c_sdo[62:0], m_sdo};
            c_com  = {c_com[62:0], m_com};
            c_al   = {c_al[62:0], m_al};
            c_dl   = {c_dl[62:0], m_dl};
            c_done = {c_done[62:0], m_done};
            c_rdy  = {c_rdy[62:0], m_rdy};
            c_busy = {c_busy[62:0], m_busy};
            c_rd[k] = m_rd;
            if (k == 1) begin write_v = nw; addr_v = na; wdata_v = nd; end
            if (k == drop_k) valid_v = 1'b0;
            if (k >= rd_start && k < rd_start + 8) sdoS_v = rbyte[7 - (k - rd_start)];
            else sdoS_v = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [7:0] e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        e = 8'b1000_0010;
        sel = 1'b0; #1;
        vectors++;
        if ({m_ss, m_sdo, m_com, m_al, m_dl, m_done, m_rdy, m_busy} !== e || m_rd !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_dflt got=%b/%h exp=%b/00", {m_ss, m_sdo, m_com, m_al, m_dl, m_done, m_rdy, m_busy}, m_rd, e);
        end
        sel = 1'b1; #1;
        vectors++;
        if ({m_ss, m_sdo, m_com, m_al, m_dl, m_done, m_rdy, m_busy} !== e || m_rd !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_alt got=%b/%h exp=%b/00", {m_ss, m_sdo, m_com, m_al, m_dl, m_done, m_rdy, m_busy}, m_rd, e);
        end
        sel = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write;
        logic [63:0] e;
        start(1'b0, 1'b1, 8'h31, 8'hA5);
        capture(19, 8'h00, 99, 1, 1'b0, 8'hFF, 8'h00);
        vectors++; e = 19'b1_00110001_10100101_00;
        if (c_sdo !== e) begin miscompares++; $display("FAIL wr_sdo got=%h exp=%h", c_sdo, e); end
        vectors++; e = 19'b1_00000000_00000000_00;
        if (c_com !== e) begin miscompares++; $display("FAIL wr_com got=%h exp=%h", c_com, e); end
        vectors++; e = 19'b0_11111111_00000000_00;
        if (c_al !== e) begin miscompares++; $display("FAIL wr_addrload got=%h exp=%h", c_al, e); end
        vectors++; e = 19'b0_00000000_11111111_00;
        if (c_dl !== e) begin miscompares++; $display("FAIL wr_dataload got=%h exp=%h", c_dl, e); end
        vectors++; e = 19'b0_00000000_00000000_11;
        if (c_ss !== e) begin miscompares++; $display("FAIL wr_ss_n got=%h exp=%h", c_ss, e); end
        vectors++; e = 19'b0_00000000_00000000_10;
        if (c_done !== e) begin miscompares++; $display("FAIL wr_done got=%h exp=%h", c_done, e); end
        vectors++; e = 19'b0_00000000_00000000_01;
        if (c_rdy !== e) begin miscompares++; $display("FAIL wr_ready got=%h exp=%h", c_rdy, e); end
        vectors++; e = 19'b1_11111111_11111111_10;
        if (c_busy !== e) begin miscompares++; $display("FAIL wr_busy got=%h exp=%h", c_busy, e); end
        vectors++;
        if (c_rd[19] !== 8'h00) begin miscompares++; $display("FAIL wr_rdata got=%h exp=00", c_rd[19]); end
    endtask

    task automatic test_read;
        logic [63:0] e;
        start(1'b0, 1'b0, 8'h32, 8'h00);
        capture(21, 8'h50, 12, 1, 1'b1, 8'hCD, 8'hEE);
        vectors++; e = 21'b0_00110010_00_00000000_00;
        if (c_sdo !== e) begin miscompares++; $display("FAIL rd_sdo got=%h exp=%h", c_sdo, e); end
        vectors++; e = 21'b1_00000000_00_00000000_00;
        if (c_com !== e) begin miscompares++; $display("FAIL rd_com got=%h exp=%h", c_com, e); end
        vectors++; e = 21'b0_11111111_00_00000000_00;
        if (c_al !== e) begin miscompares++; $display("FAIL rd_addrload got=%h exp=%h", c_al, e); end
        vectors++; e = 21'b0_00000000_00_11111111_00;
        if (c_dl !== e) begin miscompares++; $display("FAIL rd_dataload got=%h exp=%h", c_dl, e); end
        vectors++; e = 21'b0_00000000_00_00000000_11;
        if (c_ss !== e) begin miscompares++; $display("FAIL rd_ss_n got=%h exp=%h", c_ss, e); end
        vectors++; e = 21'b0_00000000_00_00000000_10;
        if (c_done !== e) begin miscompares++; $display("FAIL rd_done got=%h exp=%h", c_done, e); end
        vectors++; e = 21'b0_00000000_00_00000000_01;
        if (c_rdy !== e) begin miscompares++; $display("FAIL rd_ready got=%h exp=%h", c_rdy, e); end
        vectors++; e = 21'b1_11111111_11_11111111_10;
        if (c_busy !== e) begin miscompares++; $display("FAIL rd_busy got=%h exp=%h", c_busy, e); end
        vectors++;
        if (c_rd[19] !== 8'h00 || c_rd[20] !== 8'h50) begin
            miscompares++; $display("FAIL rd_rdata got=%h,%h exp=00,50", c_rd[19], c_rd[20]);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        start(1'b0, 1'b1, 8'h0F, 8'h3C);
        // valid stays high; fields switch to the queued read at k==1
        capture(40, 8'hC3, 31, 20, 1'b0, 8'h7E, 8'h00);
        vectors++; e = 40'b1_00001111_00111100_00_0_01111110_00_00000000_00;
        if (c_sdo !== e) begin miscompares++; $display("FAIL b2b_sdo got=%h exp=%h", c_sdo, e); end
        vectors++; e = 40'b1_00000000_00000000_00_1_00000000_00_00000000_00;
        if (c_com !== e) begin miscompares++; $display("FAIL b2b_com got=%h exp=%h", c_com, e); end
        vectors++; e = 40'b0_00000000_00000000_11_0_00000000_00_00000000_11;
        if (c_ss !== e) begin miscompares++; $display("FAIL b2b_ss_n got=%h exp=%h", c_ss, e); end
        vectors++; e = 40'b0_00000000_00000000_10_0_00000000_00_00000000_10;
        if (c_done !== e) begin miscompares++; $display("FAIL b2b_done got=%h exp=%h", c_done, e); end
        vectors++; e = 40'b0_00000000_00000000_01_0_00000000_00_00000000_01;
        if (c_rdy !== e) begin miscompares++; $display("FAIL b2b_ready got=%h exp=%h", c_rdy, e); end
        vectors++; e = 40'b1_11111111_11111111_10_1_11111111_11_11111111_10;
        if (c_busy !== e) begin miscompares++; $display("FAIL b2b_busy got=%h exp=%h", c_busy, e); end
        vectors++;
        if (c_rd[38] !== 8'h50 || c_rd[39] !== 8'hC3) begin
            miscompares++; $display("FAIL b2b_rdata got=%h,%h exp=50,C3", c_rd[38], c_rd[39]);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] e;
        logic [7:0]  p;
        start(1'b0, 1'b0, 8'h10, 8'h00);
        capture(5, 8'h00, 99, 1, 1'b0, 8'h10, 8'h00);
        vectors++; e = 5'b01111;
        if (c_al !== e || c_ss !== 64'd0) begin
            miscompares++; $display("FAIL mid_pre got=%h/%h exp=%h/0", c_al, c_ss, e);
        end
        rst = 1'b1;
        @(negedge clk);
        p = {m_ss, m_sdo, m_com, m_al, m_dl, m_done, m_rdy, m_busy};
        vectors++;
        if (p !== 8'b1000_0010 || m_rd !== 8'h00) begin
            miscompares++; $display("FAIL mid_abort got=%b/%h exp=10000010/00", p, m_rd);
        end
        rst = 1'b0;
        capture(3, 8'h00, 99, 1, 1'b0, 8'h00, 8'h00);
        vectors++; e = 3'b111;
        if (c_ss !== e || c_done !== 64'd0 || c_rdy !== e) begin
            miscompares++; $display("FAIL mid_idle got=%h/%h/%h exp=7/0/7", c_ss, c_done, c_rdy);
        end
        start(1'b0, 1'b0, 8'h44, 8'h00);
        capture(21, 8'h3C, 12, 1, 1'b0, 8'h00, 8'h00);
        vectors++; e = 21'b0_01000100_00_00000000_00;
        if (c_sdo !== e) begin miscompares++; $display("FAIL mid_rd_sdo got=%h exp=%h", c_sdo, e); end
        vectors++; e = 21'b0_00000000_00_00000000_10;
        if (c_done !== e) begin miscompares++; $display("FAIL mid_rd_done got=%h exp=%h", c_done, e); end
        vectors++;
        if (c_rd[20] !== 8'h3C) begin miscompares++; $display("FAIL mid_rd_rdata got=%h exp=3C", c_rd[20]); end
    endtask

    task automatic test_write_then_read;
        logic [63:0] e;
        start(1'b0, 1'b1, 8'hFF, 8'h00);
        capture(19, 8'h00, 99, 1, 1'b0, 8'h00, 8'hFF);
        vectors++; e = 19'b1_11111111_00000000_00;
        if (c_sdo !== e) begin miscompares++; $display("FAIL wr0_sdo got=%h exp=%h", c_sdo, e); end
        vectors++; e = 19'b1_11111111_11111111_10;
        if (c_busy !== e) begin miscompares++; $display("FAIL wr0_busy got=%h exp=%h", c_busy, e); end
        vectors++;
        if (c_rd[18] !== 8'h3C || c_rd[19] !== 8'h3C) begin
            miscompares++; $display("FAIL wr0_rdata got=%h,%h exp=3C,3C", c_rd[18], c_rd[19]);
        end
        start(1'b0, 1'b0, 8'hFF, 8'h00);
        capture(21, 8'h5A, 12, 1, 1'b1, 8'h00, 8'h00);
        vectors++; e = 21'b1_11111111_11_11111111_10;
        if (c_busy !== e) begin miscompares++; $display("FAIL rd5a_busy got=%h exp=%h", c_busy, e); end
        vectors++;
        if (c_rd[19] !== 8'h3C || c_rd[20] !== 8'h5A) begin
            miscompares++; $display("FAIL rd5a_rdata got=%h,%h exp=3C,5A", c_rd[19], c_rd[20]);
        end
    endtask

    task automatic test_no_turn_long_gap;
        logic [63:0] e;
        start(1'b1, 1'b0, 8'h00, 8'h00);
        capture(21, 8'hFF, 10, 1, 1'b1, 8'hAA, 8'h55);
        vectors++; e = 21'b0_00000000_00000000_000_0;
        if (c_sdo !== e) begin miscompares++; $display("FAIL alt_sdo got=%h exp=%h", c_sdo, e); end
        vectors++; e = 21'b1_00000000_00000000_000_0;
        if (c_com !== e) begin miscompares++; $display("FAIL alt_com got=%h exp=%h", c_com, e); end
        vectors++; e = 21'b0_00000000_11111111_000_0;
        if (c_dl !== e) begin miscompares++; $display("FAIL alt_dataload got=%h exp=%h", c_dl, e); end
        vectors++; e = 21'b0_00000000_00000000_111_1;
        if (c_ss !== e) begin miscompares++; $display("FAIL alt_ss_n got=%h exp=%h", c_ss, e); end
        vectors++; e = 21'b0_00000000_00000000_100_0;
        if (c_done !== e) begin miscompares++; $display("FAIL alt_done got=%h exp=%h", c_done, e); end
        vectors++; e = 21'b0_00000000_00000000_000_1;
        if (c_rdy !== e) begin miscompares++; $display("FAIL alt_ready got=%h exp=%h", c_rdy, e); end
        vectors++; e = 21'b1_11111111_11111111_111_0;
        if (c_busy !== e) begin miscompares++; $display("FAIL alt_busy got=%h exp=%h", c_busy, e); end
        vectors++;
        if (c_rd[17] !== 8'h00 || c_rd[18] !== 8'hFF) begin
            miscompares++; $display("FAIL alt_rdata got=%h,%h exp=00,FF", c_rd[17], c_rd[18]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_write_then_read();
        test_no_turn_long_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
